// File: rtl/clk_div_prog.sv
// Programmable clock divider: divides clk by a run-time divisor N, giving a square wave plus a once-per-period tick.
// Latency: clk_div/tick are registered one cycle behind the counter; the first tick comes N cycles after en is sampled high.
// Backpressure: div_ready drops while a new divisor waits for the current period to wrap, and rises again on that wrap edge.
module clk_div_prog #(
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_div,
    output logic             tick,
    output logic [WIDTH-1:0] active_div
);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] pend_nxt;
    logic [WIDTH-1:0] active_nxt;
    logic             clk_div_nxt;
    logic             tick_nxt;

    logic             handshake;
    logic [WIDTH-1:0] div_in_fix;
    logic [WIDTH-1:0] half;
    logic             last;

    // A new divisor is only blocked while one is already waiting for the wrap.
    assign div_ready  = (state != PEND);
    assign handshake  = div_valid && div_ready;
    // Zero would never wrap; it is treated as divide-by-one.
    assign div_in_fix = (div_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : div_in;
    // ceil(N/2) without needing an extra bit for N+1.
    assign half       = (active_div >> 1) + {{(WIDTH-1){1'b0}}, active_div[0]};
    // Wrap by equality so the counter can never pass N-1.
    assign last       = (cnt == active_div - 1'b1);

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STOP;
            cnt        <= '0;
            clk_div    <= 1'b0;
            tick       <= 1'b0;
            active_div <= DEF_DIV;
            pend_div   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            clk_div    <= clk_div_nxt;
            tick       <= tick_nxt;
            active_div <= active_nxt;
            pend_div   <= pend_nxt;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_nxt    = pend_div;
        active_nxt  = active_div;
        clk_div_nxt = clk_div;
        tick_nxt    = tick;
        case (state)
            STOP: begin
                cnt_nxt     = '0;
                clk_div_nxt = 1'b0;
                tick_nxt    = 1'b0;
                if (handshake) begin
                    active_nxt = div_in_fix;
                end
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN, PEND: begin
                if (!en) begin
                    // Stopping: a waiting divisor (or one offered right now) takes effect at once.
                    state_nxt   = STOP;
                    cnt_nxt     = '0;
                    clk_div_nxt = 1'b0;
                    tick_nxt    = 1'b0;
                    if (state == PEND) begin
                        active_nxt = pend_div;
                    end else if (handshake) begin
                        active_nxt = div_in_fix;
                    end
                end else begin
                    cnt_nxt     = last ? '0 : cnt + 1'b1;
                    tick_nxt    = last;
                    clk_div_nxt = (cnt < half);
                    if (state == RUN && handshake) begin
                        pend_nxt  = div_in_fix;
                        state_nxt = PEND;
                    end
                    // Swap only on the wrap so no period is cut short or stretched.
                    if (state == PEND && last) begin
                        active_nxt = pend_div;
                        state_nxt  = RUN;
                    end
                end
            end
            default: begin
                state_nxt   = STOP;
                cnt_nxt     = '0;
                clk_div_nxt = 1'b0;
                tick_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (default build plus a 4-bit build).
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_clk_div_prog;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [25:0] div_in;
    logic        div_valid;
    logic        div_ready;
    logic        clk_div;
    logic        tick;
    logic [25:0] active_div;

    logic        en4;
    logic [3:0]  div_in4;
    logic        div_valid4;
    logic        div_ready4;
    logic        clk_div4;
    logic        tick4;
    logic [3:0]  active_div4;

    int total = 0;
    int bad   = 0;

    clk_div_prog dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_in     (div_in),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .clk_div    (clk_div),
        .tick       (tick),
        .active_div (active_div)
    );

    clk_div_prog #(.WIDTH(4), .DEFAULT_DIV(9)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en4),
        .div_in     (div_in4),
        .div_valid  (div_valid4),
        .div_ready  (div_ready4),
        .clk_div    (clk_div4),
        .tick       (tick4),
        .active_div (active_div4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        div_valid  = 1'b0;
        en4        = 1'b0;
        div_valid4 = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic load(input logic [25:0] v);
        div_in    = v;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
    endtask

    // Steps until tick is seen; n = cycles taken, or limit+1 if it never came.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        while (n <= limit) begin
            step();
            n++;
            if (tick) break;
        end
    endtask

    int          n;
    int          ticks;
    int          highs;
    int          cycles;
    logic [9:0]  pat_c;
    logic [9:0]  pat_t;
    logic        allhigh;

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        div_in     = '0;
        div_valid  = 1'b0;
        en4        = 1'b0;
        div_in4    = '0;
        div_valid4 = 1'b0;

        // Reset state
        #12;
        chk("rst_clk_div", clk_div, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", div_ready, 1);
        chk("rst_active", active_div, 512);
        chk("rst_active4", active_div4, 9);
        rst_n = 1'b1;
        step();

        // Default divisor 512
        en = 1'b1;
        step();
        wait_tick(600, n);
        chk("def_first_tick", n, 512);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            ticks += int'(tick);
            highs += int'(clk_div);
        end
        chk("def_ticks", ticks, 1);
        chk("def_highs", highs, 256);
        chk("def_tick_at_end", tick, 1);
        chk("def_active", active_div, 512);

        // Odd divisor 5 loaded while stopped
        do_reset();
        load(26'd5);
        chk("odd_active", active_div, 5);
        chk("odd_ready", div_ready, 1);
        en = 1'b1;
        step();
        pat_c = '0;
        pat_t = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            pat_c = {pat_c[8:0], clk_div};
            pat_t = {pat_t[8:0], tick};
        end
        chk("odd_clk_pat", pat_c, 10'b1110011100);
        chk("odd_tick_pat", pat_t, 10'b0000100001);

        // Mid-run load: N=8, load 3 as cnt goes 1->2
        do_reset();
        load(26'd8);
        en = 1'b1;
        step();
        wait_tick(20, n);
        chk("mid_first_tick", n, 8);
        step();
        load(26'd3);
        chk("mid_ready_low", div_ready, 0);
        cycles = 0;
        pat_c  = '0;
        while (!div_ready && cycles < 20) begin
            pat_c = {pat_c[8:0], clk_div};
            cycles++;
            step();
        end
        chk("mid_ready_low_cycles", cycles, 6);
        chk("mid_old_tail_pat", pat_c, 10'b0000111000);
        chk("mid_wrap_tick", tick, 1);
        chk("mid_wrap_clk", clk_div, 0);
        chk("mid_active", active_div, 3);
        pat_c = '0;
        pat_t = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            pat_c = {pat_c[8:0], clk_div};
            pat_t = {pat_t[8:0], tick};
        end
        chk("mid_new_clk_pat", pat_c, 10'b0000110110);
        chk("mid_new_tick_pat", pat_t, 10'b0000001001);

        // Divisor 0 behaves as 1
        do_reset();
        load(26'd0);
        chk("zero_active", active_div, 1);
        en = 1'b1;
        step();
        allhigh = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            allhigh = allhigh & tick & clk_div;
        end
        chk("zero_all_high", allhigh, 1);

        // Stop and load in the same cycle: value goes active directly
        en        = 1'b0;
        div_in    = 26'd6;
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        chk("stopload_active", active_div, 6);
        chk("stopload_ready", div_ready, 1);
        chk("stopload_tick", tick, 0);
        chk("stopload_clk", clk_div, 0);

        // Maximum divisor on the 4-bit build
        div_in4    = 4'hF;
        div_valid4 = 1'b1;
        step();
        div_valid4 = 1'b0;
        chk("max4_active", active_div4, 15);
        en4 = 1'b1;
        step();
        n = 0;
        while (n <= 30) begin
            step();
            n++;
            if (tick4) break;
        end
        chk("max4_first_tick", n, 15);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            ticks += int'(tick4);
            highs += int'(clk_div4);
        end
        chk("max4_ticks", ticks, 1);
        chk("max4_highs", highs, 8);
        en4 = 1'b0;

        // Stop while a divisor is pending
        do_reset();
        load(26'd10);
        en = 1'b1;
        step();
        step();
        step();
        load(26'd4);
        chk("stoppend_ready_low", div_ready, 0);
        chk("stoppend_active_old", active_div, 10);
        chk("stoppend_clk_high", clk_div, 1);
        en = 1'b0;
        step();
        chk("stoppend_clk", clk_div, 0);
        chk("stoppend_tick", tick, 0);
        chk("stoppend_active", active_div, 4);
        chk("stoppend_ready", div_ready, 1);
        en = 1'b1;
        step();
        wait_tick(20, n);
        chk("stoppend_first_tick", n, 4);

        // Asynchronous reset while pending, between clock edges
        do_reset();
        load(26'd10);
        en = 1'b1;
        step();
        step();
        load(26'd4);
        chk("arst_pend_ready", div_ready, 0);
        chk("arst_pre_clk", clk_div, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk", clk_div, 0);
        chk("arst_tick", tick, 0);
        chk("arst_ready", div_ready, 1);
        chk("arst_active", active_div, 512);
        #2;
        rst_n = 1'b1;
        step();
        wait_tick(600, n);
        chk("arst_first_tick", n, 512);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
